// File: rtl/adder_4bit_core.sv
// 4-bit ripple-carry adder slice with group propagate/generate for cascading,
// plus a registered copy of {carry, sum} and the signed-overflow flag.
module adder_4bit_core (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       C_in,
   output logic [3:0] S_out,
   output logic       C_out,
   output logic       V_out,
   output logic       P_grp,
   output logic       G_grp,
   output logic [4:0] sum_q,
   output logic       v_q
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;
   logic [4:0] sum_d;

   assign p = A ^ B;
   assign g = A & B;

   always_comb begin
      c     = '0;
      S_out = '0;
      c[0]  = C_in;
      for (int i = 0; i < 4; i++) begin
         S_out[i] = p[i] ^ c[i];
         c[i+1]   = g[i] | (c[i] & p[i]);
      end
   end

   assign C_out = c[4];
   // Overflow when the carry into the sign bit differs from the carry out of it.
   assign V_out = c[3] ^ c[4];
   assign P_grp = &p;
   assign G_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

   assign sum_d = {C_out, S_out};

   always_ff @(posedge clk) begin
      if (!rst) begin
         sum_q <= 5'b0;
         v_q   <= 1'b0;
      end else begin
         sum_q <= sum_d;
         v_q   <= V_out;
      end
   end

endmodule

// File: tb/tb_adder_4bit_core.sv
// Directed-vector and exhaustive bench for adder_4bit_core, covering the
// combinational outputs and the registered path including reset behaviour.
module tb_adder_4bit_core;

   logic       clk;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic       C_in;
   logic [3:0] S_out;
   logic       C_out;
   logic       V_out;
   logic       P_grp;
   logic       G_grp;
   logic [4:0] sum_q;
   logic       v_q;

   int n_cmp;
   int n_bad;

   adder_4bit_core dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .C_in  (C_in),
      .S_out (S_out),
      .C_out (C_out),
      .V_out (V_out),
      .P_grp (P_grp),
      .G_grp (G_grp),
      .sum_q (sum_q),
      .v_q   (v_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] s;
      logic       c;
      logic       v;
      logic       p;
      logic       g;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (A=%0d B=%0d C_in=%0d)", name, act, exp,
                  A, B, C_in);
      end
   endtask

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
      @(negedge clk);
      A    = a;
      B    = b;
      C_in = cin;
      #1;
   endtask

   task automatic edge_then_settle();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[7];
   int   sv;
   logic [4:0] exp_sum;
   logic       exp_v;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      A     = 4'd0;
      B     = 4'd0;
      C_in  = 1'b0;

      //            a      b      cin   s      c     v     p     g
      vecs[0] = '{4'd0,  4'd9,  1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'd0,  4'd15, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{4'd5,  4'd10, 1'b0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{4'd7,  4'd8,  1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0};

      // Reset held for two edges; combinational path keeps tracking.
      apply(4'd3, 4'd4, 1'b0);
      for (int i = 0; i < 2; i++) begin
         edge_then_settle();
         chk("rst_sum_q", 32'(sum_q), 32'd0);
         chk("rst_v_q", 32'(v_q), 32'd0);
         chk("rst_S_out", 32'(S_out), 32'd7);
      end

      @(negedge clk);
      rst = 1'b1;
      edge_then_settle();
      chk("release_sum_q", 32'(sum_q), 32'd7);
      chk("release_v_q", 32'(v_q), 32'd0);

      apply(4'd7, 4'd1, 1'b0);
      edge_then_settle();
      chk("ovf_sum_q", 32'(sum_q), 32'd8);
      chk("ovf_v_q", 32'(v_q), 32'd1);

      @(negedge clk);
      rst = 1'b0;
      edge_then_settle();
      chk("rerst_sum_q", 32'(sum_q), 32'd0);
      chk("rerst_v_q", 32'(v_q), 32'd0);
      chk("rerst_S_out", 32'(S_out), 32'd8);
      chk("rerst_V_out", 32'(V_out), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      // Directed table: combinational outputs, then registered copy after the edge.
      for (int i = 0; i < 7; i++) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].cin);
         chk("vec_S_out", 32'(S_out), 32'(vecs[i].s));
         chk("vec_C_out", 32'(C_out), 32'(vecs[i].c));
         chk("vec_V_out", 32'(V_out), 32'(vecs[i].v));
         chk("vec_P_grp", 32'(P_grp), 32'(vecs[i].p));
         chk("vec_G_grp", 32'(G_grp), 32'(vecs[i].g));
         edge_then_settle();
         chk("vec_sum_q", 32'(sum_q), 32'({vecs[i].c, vecs[i].s}));
         chk("vec_v_q", 32'(v_q), 32'(vecs[i].v));
      end

      // Exhaustive sweep against an arithmetic model.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int ci = 0; ci < 2; ci++) begin
               apply(4'(a), 4'(b), 1'(ci));
               exp_sum = 5'(a + b + ci);
               sv = (a > 7 ? a - 16 : a) + (b > 7 ? b - 16 : b) + ci;
               exp_v = (sv > 7) || (sv < -8);
               chk("sweep_sum", 32'({C_out, S_out}), 32'(exp_sum));
               chk("sweep_V_out", 32'(V_out), 32'(exp_v));
               chk("sweep_P_grp", 32'(P_grp), 32'(((a ^ b) & 15) == 15));
               chk("sweep_G_grp", 32'(G_grp), 32'((a + b) > 15));
               chk("sweep_cascade", 32'(C_out), 32'(G_grp | (P_grp & C_in)));
               edge_then_settle();
               chk("sweep_sum_q", 32'(sum_q), 32'(exp_sum));
               chk("sweep_v_q", 32'(v_q), 32'(exp_v));
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
